// File: rtl/uart_frame_ctrl.sv
// Receive-side frame parser: SYNC, ADDR, LEN, payload, CHK, then a burst of register writes.
// All outputs are registered and land one cycle after the causing strobe; there is no backpressure, so bytes arriving during COMMIT are dropped and flagged.
module uart_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       ovr,
  output logic       busy
);

  localparam int              AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_COMMIT
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] cnt, cnt_d;
  logic [7:0]    chk, chk_d, addr, addr_d, len, len_d, idx, idx_d;
  logic          wr_en_d, frame_ok_d, frame_err_d, ovr_d;
  logic [7:0]    wr_addr_d, wr_data_d;
  logic [1:0]    err_code_d;
  logic          buf_we;
  logic          timed;
  logic [7:0]    buf_mem [2**AW];

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    chk_d      = chk;
    addr_d     = addr;
    len_d      = len;
    idx_d      = idx;
    wr_en_d    = 1'b0;
    wr_addr_d  = 8'h00;
    wr_data_d  = 8'h00;
    frame_ok_d = 1'b0;
    frame_err_d = 1'b0;
    err_code_d = 2'd0;
    ovr_d      = 1'b0;
    buf_we     = 1'b0;
    timed      = state inside {S_ADDR, S_LEN, S_PAYLOAD, S_CHK};

    // cnt already includes the strobe cycle, so the error lands exactly TIMEOUT clocks after it
    if (timed) begin
      if (rx_valid) begin
        cnt_d = TW'(1);
      end else if (cnt >= TO_LAST) begin
        state_d     = S_IDLE;
        frame_err_d = 1'b1;
        err_code_d  = 2'd3;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = S_ADDR;
          cnt_d   = TW'(1);
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          chk_d   = rx_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
          end else begin
            len_d   = rx_data;
            chk_d   = chk ^ rx_data;
            idx_d   = 8'd0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          chk_d  = chk ^ rx_data;
          idx_d  = idx + 8'd1;
          if (idx + 8'd1 == len) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk) begin
            state_d   = S_COMMIT;
            wr_en_d   = 1'b1;
            wr_addr_d = addr;
            wr_data_d = buf_mem[0];
            idx_d     = 8'd1;
          end else begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
          end
        end
      end
      S_COMMIT: begin
        ovr_d = rx_valid;
        if (idx < len) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr + idx;
          wr_data_d = buf_mem[idx[AW-1:0]];
          idx_d     = idx + 8'd1;
        end else begin
          frame_ok_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      chk       <= 8'h00;
      addr      <= 8'h00;
      len       <= 8'h00;
      idx       <= 8'h00;
      wr_en     <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      ovr       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      chk       <= chk_d;
      addr      <= addr_d;
      len       <= len_d;
      idx       <= idx_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      frame_ok  <= frame_ok_d;
      frame_err <= frame_err_d;
      err_code  <= err_code_d;
      ovr       <= ovr_d;
      busy      <= (state_d != S_IDLE);
    end
  end

  // Payload staging needs no reset; entries are always written before they are read
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[idx[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: frames are generated with known strobe cycles and the expected
// per-cycle outputs are scheduled from the frame-level timing rules, then compared every cycle.
module tb_uart_frame_ctrl;

  localparam int NC = 40000;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       wr_en, frame_ok, frame_err, ovr, busy;
  logic [7:0] wr_addr, wr_data;
  logic [1:0] err_code;

  uart_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT(64)) dut (
    .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .ovr(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  // expected outputs, indexed by cycle
  logic       exp_wr   [NC];
  logic [7:0] exp_addr [NC];
  logic [7:0] exp_data [NC];
  logic       exp_ok   [NC];
  logic       exp_err  [NC];
  logic [1:0] exp_code [NC];
  logic       exp_ovr  [NC];
  logic       exp_busy [NC];

  int         cur = 0;
  int         total = 0;
  int         bad = 0;
  logic       in_frame = 1'b0;
  logic [7:0] pl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cur, act, want);
    end
  endtask

  // one cycle of stimulus; cycle index advances just after the rising edge
  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    if (cur < NC) exp_busy[cur] = in_frame;
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic exp_write(input int c, input logic [7:0] a, input logic [7:0] d);
    exp_wr[c] = 1'b1; exp_addr[c] = a; exp_data[c] = d;
  endtask

  task automatic exp_fail(input int c, input logic [1:0] code);
    exp_err[c] = 1'b1; exp_code[c] = code;
  endtask

  task automatic clear_exp(input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      exp_wr[c] = 1'b0; exp_ok[c] = 1'b0; exp_err[c] = 1'b0;
      exp_code[c] = 2'd0; exp_ovr[c] = 1'b0;
    end
  endtask

  function automatic int sg();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
  endfunction

  function automatic logic [7:0] frame_sum(input logic [7:0] a, input int len);
    logic [7:0] x;
    x = a ^ 8'(len);
    for (int i = 0; i < len; i++) x ^= pl[i];
    return x;
  endfunction

  task automatic fill_pl();
    for (int i = 0; i < 16; i++) pl[i] = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
  endtask

  // mode: 0 good, 1 good with overrun bytes, 2 bad checksum, 3 reset at the 5th write
  task automatic frame(input logic [7:0] a, input int len, input int mode);
    int tc;
    tick(1'b1, 8'hA5);
    in_frame = 1'b1;
    gap(sg()); tick(1'b1, a);
    gap(sg()); tick(1'b1, 8'(len));
    for (int i = 0; i < len; i++) begin
      gap(sg()); tick(1'b1, pl[i]);
    end
    gap(sg());
    tc = cur;
    if (mode == 2) begin
      exp_fail(tc + 1, 2'd2);
      tick(1'b1, frame_sum(a, len) ^ 8'($urandom_range(1, 255)));
      in_frame = 1'b0;
      return;
    end
    for (int i = 0; i < len; i++) exp_write(tc + 1 + i, a + 8'(i), pl[i]);
    exp_ok[tc + len + 1] = 1'b1;
    tick(1'b1, frame_sum(a, len));
    for (int i = 1; i <= len; i++) begin
      if (mode == 3 && i == 5) begin
        clear_exp(cur, tc + len + 1);
        nrst = 1'b0;
        in_frame = 1'b0;
        gap(3);
        nrst = 1'b1;
        return;
      end
      if (mode == 1 && (i == 1 || $urandom_range(0, 2) == 0)) begin
        exp_ovr[cur + 1] = 1'b1;
        tick(1'b1, 8'($urandom));
      end else begin
        tick(1'b0, 8'h00);
      end
    end
    in_frame = 1'b0;
  endtask

  task automatic bad_len(input logic [7:0] a, input logic [7:0] lb);
    tick(1'b1, 8'hA5);
    in_frame = 1'b1;
    gap(sg()); tick(1'b1, a);
    gap(sg());
    exp_fail(cur + 1, 2'd1);
    tick(1'b1, lb);
    in_frame = 1'b0;
  endtask

  // stop after k of the bytes that follow SYNC, then go silent
  task automatic stall_frame(input int k, input int len);
    int t_last;
    tick(1'b1, 8'hA5);
    in_frame = 1'b1;
    for (int j = 0; j < k; j++) begin
      gap(sg());
      tick(1'b1, (j == 0) ? 8'($urandom) : (j == 1) ? 8'(len) : pl[j - 2]);
    end
    t_last = cur - 1;
    exp_fail(t_last + 64, 2'd3);
    gap(63);
    in_frame = 1'b0;
  endtask

  // two-byte frame with hand-computed expectations
  task automatic lit2(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] c, input logic [7:0] a1);
    tick(1'b1, 8'hA5);
    in_frame = 1'b1;
    tick(1'b1, a); tick(1'b1, 8'h02); tick(1'b1, d0); tick(1'b1, d1);
    exp_write(cur + 1, a, d0);
    exp_write(cur + 2, a1, d1);
    exp_ok[cur + 3] = 1'b1;
    tick(1'b1, c);
    check("lit_wr0_addr", wr_addr, a);
    check("lit_wr0_data", wr_data, d0);
    tick(1'b0, 8'h00);
    check("lit_wr1_addr", wr_addr, a1);
    tick(1'b0, 8'h00);
    in_frame = 1'b0;
    check("lit_ok", frame_ok, 1);
  endtask

  initial begin : compare
    int c;
    forever begin
      @(negedge clk);
      c = cur;
      if (c < NC) begin
        check("wr_en", wr_en, exp_wr[c]);
        if (exp_wr[c]) begin
          check("wr_addr", wr_addr, exp_addr[c]);
          check("wr_data", wr_data, exp_data[c]);
        end
        if (!nrst) begin
          check("rst_wr_addr", wr_addr, 0);
          check("rst_wr_data", wr_data, 0);
        end
        check("frame_ok", frame_ok, exp_ok[c]);
        check("frame_err", frame_err, exp_err[c]);
        check("err_code", err_code, exp_code[c]);
        check("ovr", ovr, exp_ovr[c]);
        check("busy", busy, exp_busy[c]);
      end
    end
  end

  initial begin : stim
    int t;
    int kind;
    int len;
    for (int c = 0; c < NC; c++) begin
      exp_wr[c] = 1'b0; exp_addr[c] = 8'h00; exp_data[c] = 8'h00; exp_ok[c] = 1'b0;
      exp_err[c] = 1'b0; exp_code[c] = 2'd0; exp_ovr[c] = 1'b0; exp_busy[c] = 1'b0;
    end

    gap(3);
    nrst = 1'b1;
    gap(2);

    // literal frames
    lit2(8'h10, 8'h11, 8'h22, 8'h21, 8'h11);
    gap(2);
    lit2(8'hFF, 8'hAA, 8'hBB, 8'hEC, 8'h00);
    gap(2);

    tick(1'b1, 8'hA5); in_frame = 1'b1; tick(1'b1, 8'h10);
    exp_fail(cur + 1, 2'd1);
    tick(1'b1, 8'h00); in_frame = 1'b0;
    check("len0_err_code", err_code, 1);
    gap(2);
    tick(1'b1, 8'hA5); in_frame = 1'b1; tick(1'b1, 8'h10);
    exp_fail(cur + 1, 2'd1);
    tick(1'b1, 8'h11); in_frame = 1'b0;
    check("len17_err_code", err_code, 1);
    gap(2);

    tick(1'b1, 8'hA5); in_frame = 1'b1;
    tick(1'b1, 8'h10); tick(1'b1, 8'h02); tick(1'b1, 8'h11); tick(1'b1, 8'h22);
    exp_fail(cur + 1, 2'd2);
    tick(1'b1, 8'h20); in_frame = 1'b0;
    check("badchk_err_code", err_code, 2);
    fill_pl();
    frame(8'h40, 2, 0);
    gap(2);

    tick(1'b1, 8'hA5); in_frame = 1'b1; tick(1'b1, 8'h10);
    t = cur - 1;
    exp_fail(t + 64, 2'd3);
    gap(63);
    in_frame = 1'b0;
    check("timeout_cycle", cur - t, 64);
    check("timeout_err", frame_err, 1);
    check("timeout_code", err_code, 3);
    check("timeout_busy", busy, 0);
    gap(2);

    fill_pl();
    frame(8'hF8, 16, 1);
    gap(2);
    fill_pl();
    frame(8'h30, 16, 3);
    gap(2);
    fill_pl();
    frame(8'h31, 3, 0);
    gap(2);

    // randomized mix
    for (int n = 0; n < 150 && cur < NC - 300; n++) begin
      kind = $urandom_range(0, 7);
      len  = $urandom_range(1, 16);
      fill_pl();
      case (kind)
        0, 1, 2: frame(8'($urandom), len, 0);
        3:       frame(8'($urandom), len, 1);
        4:       bad_len(8'($urandom), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
        5:       frame(8'($urandom), len, 2);
        6:       stall_frame($urandom_range(0, len + 2), len);
        default: begin
          t = $urandom_range(1, 4);
          for (int j = 0; j < t; j++) begin
            kind = $urandom_range(0, 255);
            tick(1'b1, (8'(kind) == 8'hA5) ? 8'h5A : 8'(kind));
          end
        end
      endcase
      gap($urandom_range(0, 3));
    end

    gap(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Receive-side frame controller sitting directly behind the `uartRX` byte receiver. It parses the received byte stream into framed write commands and stages each payload in an internal buffer. It verifies an XOR checksum and only then commits the payload, one byte per cycle, to a downstream register bank. Malformed, corrupted or stalled frames are discarded and never produce writes.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `MAX_LEN`, 16, maximum payload bytes (1..255); sizes the staging buffer.
- `TIMEOUT`, 64, maximum idle clocks between bytes inside a frame.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  byte from `uartRX`; sampled only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe, byte available.
- `wr_en`  out  1  register-bank write strobe.
- `wr_addr`  out  8  write address.
- `wr_data`  out  8  write data.
- `frame_ok`  out  1  one-cycle pulse, frame committed.
- `frame_err`  out  1  one-cycle pulse, frame discarded.
- `err_code`  out  2  cause, valid with `frame_err`: 1 = bad length, 2 = checksum, 3 = timeout.
- `ovr`  out  1  one-cycle pulse, byte dropped during COMMIT.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Frame format, in order: SYNC, ADDR, LEN, LEN payload bytes, CHK.
- CHK = ADDR ^ LEN ^ all payload bytes.
- States: IDLE, ADDR, LEN, PAYLOAD, CHK, COMMIT.
- IDLE: on `rx_valid` with `rx_data`==SYNC_BYTE → ADDR. Any other byte is ignored with no error.
- ADDR: on `rx_valid`, latch address, seed checksum with the byte → LEN.
- LEN: on `rx_valid`:
  - If byte is 0 or greater than MAX_LEN → `frame_err`, code 1, IDLE.
  - Otherwise latch length, XOR into checksum, clear payload index → PAYLOAD.
- PAYLOAD: on each `rx_valid`, store byte at buffer[index], XOR into checksum, increment index. After byte LEN → CHK.
- CHK: on `rx_valid`:
  - Byte equals running checksum → COMMIT.
  - Otherwise → `frame_err`, code 2, IDLE, no writes.
- COMMIT: for i = 0..LEN-1, one per cycle, drive `wr_en`=1, `wr_addr`=(ADDR+i) mod 256, `wr_data`=buffer[i]. After the last write → IDLE with `frame_ok`.
- Timeout: an inter-byte counter runs in ADDR, LEN, PAYLOAD and CHK.
  - Cleared on entry to those states and on every `rx_valid`.
  - Reaching TIMEOUT clocks without a byte → `frame_err`, code 3, IDLE.
- Overrun: an `rx_valid` arriving during COMMIT is dropped and pulses `ovr` in the next cycle. State and buffer are unaffected. SYNC is not detected until IDLE.
- A SYNC byte received inside a frame is treated as ordinary data. No resynchronisation occurs.

## Timing
- Reset: state IDLE, counters 0, checksum 0. All outputs 0: `wr_en`, `wr_addr`, `wr_data`, `frame_ok`, `frame_err`, `err_code`, `ovr`, `busy`. Buffer contents need not be cleared.
- All outputs are registered.
- Length or checksum error: `frame_err`/`err_code` high in cycle T+1 when the offending byte is strobed in cycle T. State is IDLE in T+1.
- Timeout: `frame_err` fires when the counter reaches TIMEOUT, i.e. TIMEOUT clocks after the last strobe (or after entering ADDR).
- Commit with CHK strobed in cycle T: `wr_en` high in cycles T+1..T+LEN. `frame_ok` high in T+LEN+1, in which the state is IDLE.
- An `rx_valid` in cycle T+LEN+1 is processed normally by IDLE.
- `err_code` holds its value only while `frame_err`=1; otherwise it is 0.
- Reset asserted mid-frame or mid-COMMIT: outputs clear immediately (asynchronously). No further writes occur; the partial frame is lost.

## Test plan
- Good frame A5 10 02 11 22 21 → writes 0x10←0x11 then 0x11←0x22 on consecutive cycles, then `frame_ok` one cycle later; `frame_err` never asserted.
- Address wrap A5 FF 02 AA BB EC → writes 0xFF←0xAA, 0x00←0xBB, then `frame_ok`.
- Bad length A5 10 00 → `frame_err`=1 with `err_code`=1 one cycle after the LEN strobe; zero writes. The same result is required for LEN=0x11 with MAX_LEN=16.
- Bad checksum A5 10 02 11 22 20 → `frame_err`, `err_code`=2; zero writes. A following good frame commits correctly.
- Timeout A5 10 then no strobes → `frame_err`, `err_code`=3 exactly 64 clocks after the 0x10 strobe; `busy` falls in the same cycle.
- Overrun/reset: send a MAX_LEN frame, strobe a byte during COMMIT → `ovr` pulses and all 16 writes still occur. Repeat with `nrst` low during the 5th write → no further `wr_en`, all outputs 0.
